kf8259_ack_sequencer: RTL and testbench

KF8259_ACK_SEQUENCER -- requirements
Module: kf8259_ack_sequencer

---
 rtl/kf8259_common_package.sv | 51 +++++
 rtl/kf8259_ack_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_kf8259_ack_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kf8259_common_package.sv
// KF8259_Common_Package
//   Shared types, constants and helpers for the KF8259 interrupt controller
//   blocks.
//   - ack_state_t     : states of the INTA acknowledge sequencer
//   - OCW2_*          : OCW2 command encodings (R, SL, EOI = ocw2_data[7:5])
//   - index_to_one_hot: 3-bit level -> 8-bit one-hot mask
//   - one_hot_to_index: 8-bit one-hot mask -> 3-bit level
package KF8259_Common_Package;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PENDING = 3'd1,
    ACK1    = 3'd2,
    ACK2    = 3'd3,
    DONE    = 3'd4
  } ack_state_t;

  // OCW2 {R, SL, EOI} command field.
  localparam logic [2:0] OCW2_ROTATE_AEOI_CLEAR    = 3'b000;
  localparam logic [2:0] OCW2_NONSPECIFIC_EOI      = 3'b001;
  localparam logic [2:0] OCW2_NOP                  = 3'b010;
  localparam logic [2:0] OCW2_SPECIFIC_EOI         = 3'b011;
  localparam logic [2:0] OCW2_ROTATE_AEOI_SET      = 3'b100;
  localparam logic [2:0] OCW2_ROTATE_NONSPECIFIC   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIORITY         = 3'b110;
  localparam logic [2:0] OCW2_ROTATE_SPECIFIC      = 3'b111;

  // Value of priority_rotate meaning "no rotation" (IR7 lowest priority).
  localparam logic [2:0] NO_ROTATION = 3'b111;

  function automatic logic [7:0] index_to_one_hot(input logic [2:0] index);
    logic [7:0] one_hot;
    one_hot = 8'h00;
    one_hot[index] = 1'b1;
    return one_hot;
  endfunction

  // Inputs are expected to be one-hot; if several bits are set the highest
  // index wins.
  function automatic logic [2:0] one_hot_to_index(input logic [7:0] one_hot);
    logic [2:0] index;
    index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (one_hot[i]) begin
        index = 3'(i);
      end
    end
    return index;
  endfunction

endpackage

// File: rtl/kf8259_ack_sequencer.sv
// kf8259_ack_sequencer
//   Runs the two-pulse INTA acknowledge cycle of the 8259: raises INT while a
//   request is pending, freezes the winning level on the first INTA, latches
//   it into the in-service stage, drives the vector during the second INTA
//   and optionally issues the automatic EOI. It also decodes OCW2 EOI and
//   priority-rotation commands.
// Ports
//   clock                    : rising-edge clock
//   reset_n                  : asynchronous active-low reset
//   highest_level_request    : one-hot winning request (0 = none)
//   highest_level_in_service : one-hot highest level in service
//   interrupt_acknowledge_n  : synchronized INTA#, active-low
//   vector_base              : ICW2 T7..T3
//   auto_eoi                 : ICW4 AEOI
//   ocw2_write / ocw2_data   : one-cycle OCW2 strobe and byte
//   interrupt_to_cpu         : INT
//   latch_in_service         : one-cycle strobe latching 'interrupt'
//   interrupt                : frozen one-hot level being acknowledged
//   end_of_interrupt         : one-cycle EOI clear mask
//   priority_rotate          : lowest-priority level (3'b111 = none)
//   vector_out               : acknowledge vector
//   vector_out_enable        : vector drive enable
module kf8259_ack_sequencer
  import KF8259_Common_Package::*;
#(
  parameter int SPURIOUS_LEVEL = 7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] highest_level_request,
  input  logic [7:0] highest_level_in_service,
  input  logic       interrupt_acknowledge_n,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  output logic       interrupt_to_cpu,
  output logic       latch_in_service,
  output logic [7:0] interrupt,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic [7:0] vector_out,
  output logic       vector_out_enable
);

  localparam logic [2:0] SPURIOUS_INDEX = 3'(SPURIOUS_LEVEL);

  ack_state_t state_reg;
  logic       inta_reg;
  logic [2:0] level_reg;
  logic       spurious_reg;

  logic       inta_fall;
  logic       inta_rise;
  logic       request_present;

  logic [2:0] ocw2_command;
  logic [2:0] ocw2_level;
  logic       ocw2_unused;
  logic [7:0] ocw2_eoi_mask;
  logic       ocw2_rotate_valid;
  logic [2:0] ocw2_rotate_level;
  logic [7:0] auto_eoi_mask;

  // Edges are seen in the first cycle the input differs from its copy.
  assign inta_fall       = inta_reg & ~interrupt_acknowledge_n;
  assign inta_rise       = ~inta_reg & interrupt_acknowledge_n;
  assign request_present = |highest_level_request;

  assign ocw2_command = ocw2_data[7:5];
  assign ocw2_level   = ocw2_data[2:0];
  // Bits 4:3 are fixed 00 in an OCW2 byte and carry no command information.
  assign ocw2_unused  = ^ocw2_data[4:3];

  always_comb begin
    ocw2_eoi_mask     = 8'h00;
    ocw2_rotate_valid = 1'b0;
    ocw2_rotate_level = NO_ROTATION;
    if (ocw2_write) begin
      case (ocw2_command)
        OCW2_NONSPECIFIC_EOI: begin
          ocw2_eoi_mask = highest_level_in_service;
        end
        OCW2_SPECIFIC_EOI: begin
          ocw2_eoi_mask = index_to_one_hot(ocw2_level);
        end
        OCW2_ROTATE_NONSPECIFIC: begin
          ocw2_eoi_mask = highest_level_in_service;
          // Nothing in service: no level is cleared, so nothing to rotate.
          if (|highest_level_in_service) begin
            ocw2_rotate_valid = 1'b1;
            ocw2_rotate_level = one_hot_to_index(highest_level_in_service);
          end
        end
        OCW2_ROTATE_SPECIFIC: begin
          ocw2_eoi_mask     = index_to_one_hot(ocw2_level);
          ocw2_rotate_valid = 1'b1;
          ocw2_rotate_level = ocw2_level;
        end
        OCW2_SET_PRIORITY: begin
          ocw2_rotate_valid = 1'b1;
          ocw2_rotate_level = ocw2_level;
        end
        default: begin
        end
      endcase
    end
  end

  // The automatic EOI is issued on the ACK2->DONE transition so that the
  // pulse is visible while the FSM sits in DONE.
  always_comb begin
    auto_eoi_mask = 8'h00;
    if ((state_reg == ACK2) && inta_rise && auto_eoi && !spurious_reg) begin
      auto_eoi_mask = interrupt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      inta_reg          <= 1'b1;
      level_reg         <= 3'd0;
      spurious_reg      <= 1'b0;
      interrupt_to_cpu  <= 1'b0;
      latch_in_service  <= 1'b0;
      interrupt         <= 8'h00;
      end_of_interrupt  <= 8'h00;
      priority_rotate   <= NO_ROTATION;
      vector_out        <= 8'h00;
      vector_out_enable <= 1'b0;
    end else begin
      inta_reg         <= interrupt_acknowledge_n;
      latch_in_service <= 1'b0;
      // Auto-EOI and an OCW2 EOI landing in the same cycle are merged.
      end_of_interrupt <= ocw2_eoi_mask | auto_eoi_mask;
      if (ocw2_rotate_valid) begin
        priority_rotate <= ocw2_rotate_level;
      end

      case (state_reg)
        IDLE, PENDING: begin
          if (inta_fall) begin
            // First INTA: freeze the winner; an empty request is spurious
            // and reports SPURIOUS_LEVEL without touching in-service.
            state_reg        <= ACK1;
            interrupt        <= highest_level_request;
            latch_in_service <= request_present;
            spurious_reg     <= ~request_present;
            level_reg        <= request_present ? one_hot_to_index(highest_level_request)
                                                : SPURIOUS_INDEX;
            interrupt_to_cpu <= 1'b0;
          end else if (request_present) begin
            state_reg        <= PENDING;
            interrupt_to_cpu <= 1'b1;
          end else begin
            state_reg        <= IDLE;
            interrupt_to_cpu <= 1'b0;
          end
        end
        ACK1: begin
          if (inta_fall) begin
            state_reg         <= ACK2;
            vector_out        <= {vector_base, level_reg};
            vector_out_enable <= 1'b1;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            state_reg         <= DONE;
            vector_out        <= 8'h00;
            vector_out_enable <= 1'b0;
          end
        end
        DONE: begin
          state_reg    <= IDLE;
          interrupt    <= 8'h00;
          spurious_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kf8259_ack_sequencer.sv
// tb_kf8259_ack_sequencer
//   Table-driven check of the acknowledge sequencer. Each table row holds
//   the inputs applied during one clock cycle and the outputs expected in
//   that same cycle (i.e. the registered response to earlier rows). The
//   coincident-EOI and mid-acknowledge reset cases follow as hand-written
//   sequences.
module tb_kf8259_ack_sequencer;

  logic       clock;
  logic       reset_n;
  logic [7:0] highest_level_request;
  logic [7:0] highest_level_in_service;
  logic       interrupt_acknowledge_n;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       ocw2_write;
  logic [7:0] ocw2_data;
  logic       interrupt_to_cpu;
  logic       latch_in_service;
  logic [7:0] interrupt;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] vector_out;
  logic       vector_out_enable;

  int compared   = 0;
  int mismatched = 0;

  kf8259_ack_sequencer #(.SPURIOUS_LEVEL(7)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .highest_level_request    (highest_level_request),
    .highest_level_in_service (highest_level_in_service),
    .interrupt_acknowledge_n  (interrupt_acknowledge_n),
    .vector_base              (vector_base),
    .auto_eoi                 (auto_eoi),
    .ocw2_write               (ocw2_write),
    .ocw2_data                (ocw2_data),
    .interrupt_to_cpu         (interrupt_to_cpu),
    .latch_in_service         (latch_in_service),
    .interrupt                (interrupt),
    .end_of_interrupt         (end_of_interrupt),
    .priority_rotate          (priority_rotate),
    .vector_out               (vector_out),
    .vector_out_enable        (vector_out_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] req;
    logic [7:0] isr;
    logic       inta;
    logic       aeoi;
    logic       wr;
    logic [7:0] data;
    logic       e_int;
    logic       e_lat;
    logic [7:0] e_irq;
    logic [7:0] e_eoi;
    logic [2:0] e_rot;
    logic [7:0] e_vec;
    logic       e_ven;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] req, input logic [7:0] isr,
                              input logic inta, input logic aeoi,
                              input logic wr, input logic [7:0] data,
                              input logic e_int, input logic e_lat,
                              input logic [7:0] e_irq, input logic [7:0] e_eoi,
                              input logic [2:0] e_rot, input logic [7:0] e_vec,
                              input logic e_ven);
    vec_t v;
    v.req = req; v.isr = isr; v.inta = inta; v.aeoi = aeoi;
    v.wr = wr; v.data = data;
    v.e_int = e_int; v.e_lat = e_lat; v.e_irq = e_irq; v.e_eoi = e_eoi;
    v.e_rot = e_rot; v.e_vec = e_vec; v.e_ven = e_ven;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] actual,
                       input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " interrupt_to_cpu"}, 8'(interrupt_to_cpu), 8'(v.e_int));
    check({tag, " latch_in_service"}, 8'(latch_in_service), 8'(v.e_lat));
    check({tag, " interrupt"}, interrupt, v.e_irq);
    check({tag, " end_of_interrupt"}, end_of_interrupt, v.e_eoi);
    check({tag, " priority_rotate"}, 8'(priority_rotate), 8'(v.e_rot));
    check({tag, " vector_out"}, vector_out, v.e_vec);
    check({tag, " vector_out_enable"}, 8'(vector_out_enable), 8'(v.e_ven));
  endtask

  // Apply inputs just after the rising edge, then move to the falling edge
  // where the outputs of this cycle are sampled.
  task automatic step(input logic [7:0] req, input logic inta,
                      input logic wr, input logic [7:0] data);
    @(posedge clock);
    #1;
    highest_level_request   = req;
    interrupt_acknowledge_n = inta;
    ocw2_write              = wr;
    ocw2_data               = data;
    @(negedge clock);
  endtask

  initial begin
    reset_n                  = 1'b0;
    highest_level_request    = 8'h00;
    highest_level_in_service = 8'h00;
    interrupt_acknowledge_n  = 1'b1;
    vector_base              = 5'h08;
    auto_eoi                 = 1'b0;
    ocw2_write               = 1'b0;
    ocw2_data                = 8'h00;

    //            req    isr  inta aeoi wr data   int lat irq    eoi    rot   vec    ven
    // IRQ3, two INTA pulses, no auto-EOI; first row is the reset state.
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h08, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h08, 8'h00, 1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h08, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'h08, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h08, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h08, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h08, 8'h00, 3'd7, 8'h43, 1));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h08, 8'h00, 3'd7, 8'h43, 1));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h08, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    // Request withdrawn while pending: INT rises then falls.
    vecs.push_back(mk(8'h04, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    // IRQ3 with auto-EOI: EOI 8'h08 in the cycle after the INTA rise.
    vecs.push_back(mk(8'h08, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h08, 8'h00, 1, 1, 0, 8'h00, 1, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h08, 8'h00, 0, 1, 0, 8'h00, 1, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 1, 8'h08, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h08, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h08, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h08, 8'h00, 3'd7, 8'h43, 1));
    vecs.push_back(mk(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h08, 8'h00, 3'd7, 8'h43, 1));
    vecs.push_back(mk(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h08, 8'h08, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    // Spurious acknowledge (no request): no latch, vector 8'h47, no auto-EOI.
    vecs.push_back(mk(8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h47, 1));
    vecs.push_back(mk(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h47, 1));
    vecs.push_back(mk(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    // OCW2 commands.
    vecs.push_back(mk(8'h00, 8'h10, 1, 0, 1, 8'hA0, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h10, 1, 0, 1, 8'hC2, 0, 0, 8'h00, 8'h10, 3'd4, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 1, 8'hA0, 0, 0, 8'h00, 8'h00, 3'd2, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h10, 1, 0, 1, 8'h80, 0, 0, 8'h00, 8'h00, 3'd2, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h10, 1, 0, 1, 8'h20, 0, 0, 8'h00, 8'h00, 3'd2, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 1, 8'h20, 0, 0, 8'h00, 8'h10, 3'd2, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 1, 8'hE5, 0, 0, 8'h00, 8'h00, 3'd2, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 1, 8'h63, 0, 0, 8'h00, 8'h20, 3'd5, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h08, 3'd5, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 3'd5, 8'h00, 0));

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock);
      #1;
      highest_level_request    = vecs[i].req;
      highest_level_in_service = vecs[i].isr;
      interrupt_acknowledge_n  = vecs[i].inta;
      auto_eoi                 = vecs[i].aeoi;
      ocw2_write               = vecs[i].wr;
      ocw2_data                = vecs[i].data;
      @(negedge clock);
      $display("row %0d: int=%b lat=%b irq=%h eoi=%h rot=%0d vec=%h ven=%b",
               i, interrupt_to_cpu, latch_in_service, interrupt,
               end_of_interrupt, priority_rotate, vector_out, vector_out_enable);
      check_all($sformatf("row%0d", i), vecs[i]);
    end

    // Auto-EOI of IRQ1 coincident with specific EOI of IRQ5 (OCW2 8'h65).
    highest_level_in_service = 8'h00;
    auto_eoi = 1'b1;
    step(8'h02, 1'b1, 1'b0, 8'h00);
    step(8'h02, 1'b1, 1'b0, 8'h00);
    check("coinc int_pending", 8'(interrupt_to_cpu), 8'h01);
    step(8'h02, 1'b0, 1'b0, 8'h00);
    step(8'h00, 1'b1, 1'b0, 8'h00);
    check("coinc latch", 8'(latch_in_service), 8'h01);
    check("coinc interrupt", interrupt, 8'h02);
    step(8'h00, 1'b0, 1'b0, 8'h00);
    step(8'h00, 1'b0, 1'b0, 8'h00);
    check("coinc vector", vector_out, 8'h41);
    step(8'h00, 1'b1, 1'b1, 8'h65);
    step(8'h00, 1'b1, 1'b0, 8'h00);
    $display("coincident: eoi=%h rot=%0d", end_of_interrupt, priority_rotate);
    check("coinc eoi_merged", end_of_interrupt, 8'h22);
    check("coinc rotate_kept", 8'(priority_rotate), 8'h05);
    step(8'h00, 1'b1, 1'b0, 8'h00);
    check("coinc eoi_single", end_of_interrupt, 8'h00);

    // Reset asserted between the two INTA pulses.
    auto_eoi = 1'b0;
    step(8'h08, 1'b1, 1'b0, 8'h00);
    step(8'h08, 1'b1, 1'b0, 8'h00);
    step(8'h08, 1'b0, 1'b0, 8'h00);
    step(8'h00, 1'b1, 1'b0, 8'h00);
    check("rst latch_before", 8'(latch_in_service), 8'h01);
    reset_n = 1'b0;
    #1;
    $display("mid-ack reset: int=%b lat=%b irq=%h rot=%0d", interrupt_to_cpu,
             latch_in_service, interrupt, priority_rotate);
    check("rst latch", 8'(latch_in_service), 8'h00);
    check("rst interrupt", interrupt, 8'h00);
    check("rst rotate", 8'(priority_rotate), 8'h07);
    check("rst eoi", end_of_interrupt, 8'h00);
    step(8'h00, 1'b1, 1'b0, 8'h00);
    reset_n = 1'b1;
    step(8'h00, 1'b0, 1'b0, 8'h00);
    check("rst int_after", 8'(interrupt_to_cpu), 8'h00);
    step(8'h00, 1'b0, 1'b0, 8'h00);
    check("rst no_latch", 8'(latch_in_service), 8'h00);
    check("rst ven_fall", 8'(vector_out_enable), 8'h00);
    step(8'h00, 1'b1, 1'b0, 8'h00);
    check("rst ven_rise", 8'(vector_out_enable), 8'h00);
    step(8'h00, 1'b1, 1'b0, 8'h00);
    check("rst ven_after", 8'(vector_out_enable), 8'h00);
    check("rst vec_after", vector_out, 8'h00);
    check("rst eoi_after", end_of_interrupt, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
